// File: rtl/temp_hyst_controller.sv
// Thermostat core: heat/cool decision with a hysteresis band, minimum dwell time,
// mode gating and a sensor-loss watchdog. All actuator outputs come from registers.
module temp_hyst_controller #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned HYST      = 2,
  parameter int unsigned MIN_DWELL = 4,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] temperature,
  input  logic [WIDTH-1:0] set_point,
  input  logic             sensor_valid,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             fault_clr,
  output logic             heat,
  output logic             cold,
  output logic             fault,
  output logic [1:0]       state
);

  localparam int unsigned CW = WIDTH + 1;
  localparam int unsigned DW = $clog2(MIN_DWELL + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] HYST_X    = CW'(HYST);
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
  localparam logic [TW-1:0] WD_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HEAT  = 2'd1,
    S_COOL  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [DW-1:0]   dwell_q;
  logic [TW-1:0]   wd_q;
  logic            heat_d;
  logic            cold_d;
  logic            fault_d;

  // One extra bit so temperature + HYST and set_point + HYST never wrap.
  logic [CW-1:0]   temp_x;
  logic [CW-1:0]   set_x;
  logic            heat_req;
  logic            cool_req;
  logic            heat_done;
  logic            cool_done;
  logic            heat_ok;
  logic            cool_ok;
  logic            dwell_ok;
  logic            wd_expire;
  logic            mode_block;

  assign temp_x    = {1'b0, temperature};
  assign set_x     = {1'b0, set_point};
  assign heat_req  = (temp_x + HYST_X) < set_x;
  assign cool_req  = temp_x > (set_x + HYST_X);
  assign heat_done = temp_x >= set_x;
  assign cool_done = temp_x <= set_x;
  assign heat_ok   = mode[0];
  assign cool_ok   = mode[1];
  assign dwell_ok  = dwell_q >= DWELL_MAX;

  // Expiry lands on the edge that closes the TIMEOUT-th consecutive invalid cycle.
  assign wd_expire  = enable && !sensor_valid && (state_q != S_FAULT) && (wd_q == WD_LAST);
  assign mode_block = ((state_q == S_HEAT) && !heat_ok) || ((state_q == S_COOL) && !cool_ok);

  // State register plus registered actuator decode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      heat    <= 1'b0;
      cold    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      heat    <= heat_d;
      cold    <= cold_d;
      fault   <= fault_d;
    end
  end

  assign state = state_q;

  // Next-state selection in strict priority order.
  always_comb begin
    state_d = state_q;
    if (state_q == S_FAULT) begin
      if (fault_clr) state_d = S_IDLE;
    end else if (wd_expire) begin
      state_d = S_FAULT;
    end else if (!enable || mode_block) begin
      state_d = S_IDLE;
    end else if (sensor_valid && dwell_ok) begin
      unique case (state_q)
        S_IDLE: begin
          if (heat_req && heat_ok)      state_d = S_HEAT;
          else if (cool_req && cool_ok) state_d = S_COOL;
        end
        S_HEAT:  if (heat_done) state_d = S_IDLE;
        S_COOL:  if (cool_done) state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Output decode of the upcoming state, captured alongside it.
  always_comb begin
    heat_d  = 1'b0;
    cold_d  = 1'b0;
    fault_d = 1'b0;
    unique case (state_d)
      S_HEAT:  heat_d  = 1'b1;
      S_COOL:  cold_d  = 1'b1;
      S_FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

  // Dwell counter: restarts at 1 on every state change, saturates at MIN_DWELL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_q <= DWELL_MAX;
    end else if (state_d != state_q) begin
      dwell_q <= DW'(1);
    end else if (!dwell_ok) begin
      dwell_q <= dwell_q + DW'(1);
    end
  end

  // Watchdog: frozen in FAULT, cleared on exit, on valid samples and while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q <= '0;
    end else if (state_q == S_FAULT) begin
      if (state_d != S_FAULT) wd_q <= '0;
    end else if (sensor_valid || !enable) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + TW'(1);
    end
  end

endmodule

// File: tb/tb_temp_hyst_controller.sv
// Scoreboard bench for temp_hyst_controller: stimulus pushes hand-computed expected
// states per cycle, an independent monitor pops and compares after every rising edge.
module tb_temp_hyst_controller;

  localparam int unsigned W = 8;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HEAT  = 2'd1;
  localparam logic [1:0] COOL  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] temperature;
  logic [W-1:0] set_point;
  logic         sensor_valid;
  logic         enable;
  logic [1:0]   mode;
  logic         fault_clr;
  logic         heat;
  logic         cold;
  logic         fault;
  logic [1:0]   state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] exp_q[$];
  string      name_q[$];

  temp_hyst_controller #(
    .WIDTH(8), .HYST(2), .MIN_DWELL(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .temperature(temperature), .set_point(set_point),
    .sensor_valid(sensor_valid), .enable(enable), .mode(mode), .fault_clr(fault_clr),
    .heat(heat), .cold(cold), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got {state,heat,cold,fault}=%b required %b at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [4:0] expect_vec(input logic [1:0] s);
    return {s, s == HEAT, s == COOL, s == FAULT};
  endfunction

  // Queue n cycles of the same expected state; inputs are already applied.
  task automatic run(input int n, input logic [1:0] e, input string nm);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(negedge clk);
    end
  endtask

  task automatic drive(input logic [W-1:0] t, input logic [W-1:0] s, input logic v);
    temperature  = t;
    set_point    = s;
    sensor_valid = v;
  endtask

  // Monitor: every edge is a DUT output; compare against the oldest expectation.
  initial begin
    logic [1:0] e;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, {state, heat, cold, fault}, expect_vec(e));
      end
    end
  end

  initial begin
    reset_n = 1'b1;
    enable = 1'b0; mode = 2'b11; fault_clr = 1'b0;
    drive(8'd0, 8'd0, 1'b0);
    #1 reset_n = 1'b0;
    #2 check("reset_state", {state, heat, cold, fault}, 5'b00000);
    @(negedge clk);
    reset_n = 1'b1;

    // First heat straight out of reset (dwell preset satisfied)
    enable = 1'b1; mode = 2'b11;
    drive(8'd17, 8'd20, 1'b1);  run(1, HEAT, "first_heat");
    // Hysteresis: 19 keeps heating, 20 ends it once dwell is met
    drive(8'd19, 8'd20, 1'b1);  run(3, HEAT, "heat_hold_19");
    drive(8'd20, 8'd20, 1'b1);  run(1, IDLE, "heat_done_20");
    drive(8'd18, 8'd20, 1'b1);  run(3, IDLE, "idle_18_dwell");
    drive(8'd22, 8'd20, 1'b1);  run(1, IDLE, "no_cool_22");
    drive(8'd23, 8'd20, 1'b1);  run(1, COOL, "cool_23");
    drive(8'd20, 8'd20, 1'b1);  run(3, COOL, "cool_dwell");
                                run(1, IDLE, "cool_done");
    // Dwell: HEAT at N, over-temp from N+1, released at N+4
                                run(3, IDLE, "idle_dwell");
    drive(8'd17, 8'd20, 1'b1);  run(1, HEAT, "dwell_enter");
    drive(8'd25, 8'd20, 1'b1);  run(3, HEAT, "dwell_hold");
                                run(1, IDLE, "dwell_release");
    drive(8'd20, 8'd20, 1'b1);  run(3, IDLE, "idle_dwell2");
    drive(8'd17, 8'd20, 1'b1);  run(1, HEAT, "heat_again");
    enable = 1'b0;              run(1, IDLE, "disable_now");
                                run(1, IDLE, "disable_hold");
    // Mode gating
    enable = 1'b1; mode = 2'b10;
    drive(8'd10, 8'd20, 1'b1);  run(5, IDLE, "cool_only_no_heat");
    mode = 2'b11;
    drive(8'd23, 8'd20, 1'b1);  run(1, COOL, "auto_cool");
    mode = 2'b01;               run(2, IDLE, "heat_only_drop_cool");
    // Watchdog: 15 invalid cycles are tolerated
    mode = 2'b11;
    drive(8'd20, 8'd20, 1'b1);  run(1, IDLE, "wd_prime");
    drive(8'd99, 8'd0, 1'b0);   run(15, IDLE, "wd_15_invalid");
    drive(8'd20, 8'd20, 1'b1);  run(1, IDLE, "wd_revalid");
    drive(8'd17, 8'd20, 1'b1);  run(1, HEAT, "wd_heat");
    drive(8'd200, 8'd0, 1'b0);  run(15, HEAT, "wd_heat_invalid");
                                run(1, FAULT, "wd_expire_16");
    drive(8'd17, 8'd20, 1'b1);  run(2, FAULT, "fault_sticky");
    fault_clr = 1'b1;           run(1, IDLE, "fault_clear");
    fault_clr = 1'b0;           run(3, IDLE, "fault_exit_dwell");
                                run(1, HEAT, "post_fault_heat");
    // Width edges
    drive(8'd200, 8'd200, 1'b1); run(3, HEAT, "heat_dwell3");
                                 run(1, IDLE, "heat_off_200");
    drive(8'd254, 8'd255, 1'b1); run(4, IDLE, "no_heat_254_255");
    drive(8'd252, 8'd255, 1'b1); run(1, HEAT, "heat_252_255");
    drive(8'd255, 8'd255, 1'b1); run(3, HEAT, "heat_dwell4");
                                 run(1, IDLE, "heat_off_255");
    drive(8'd255, 8'd254, 1'b1); run(4, IDLE, "no_cool_255_254");
    drive(8'd255, 8'd252, 1'b1); run(1, COOL, "cool_255_252");
    fault_clr = 1'b1;            run(1, COOL, "fault_clr_in_cool");
    fault_clr = 1'b0;

    // Let the monitor drain, bounded
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", 5'(exp_q.size()), 5'd0);

    // Asynchronous reset mid-COOL drops everything without a clock edge
    #2 reset_n = 1'b0;
    #1 check("async_reset", {state, heat, cold, fault}, 5'b00000);
    @(negedge clk);
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
